// File: rtl/hdlc_rx_drain.sv
// hdlc_rx_drain: register-bus master that empties received frames out of the
// Hdlc controller (Rx_SC, Rx_Len, then Rx_Len bytes of Rx_Buff) and presents
// them as a valid/ready byte stream with last/error markers.
//
// Optional feature macro: HDLC_RX_DRAIN_ERRBEAT_EN
//   defined   - an errored frame emits one error beat (m_err=1, m_last=1,
//               m_data=status) before it is dropped.
//   undefined - errored frames are dropped silently; m_err is tied 0.
//
// Ports:
//   Clk, Rst             clock (rising edge), async active-low reset
//   Enable, Rx_Ready     frame start qualifier, Hdlc frame-available pin
//   Address, ReadEnable, WriteEnable, DataIn, DataOut   Hdlc register bus
//   m_valid, m_ready, m_data, m_last, m_err             output byte stream
//   Busy                 high in every state except IDLE
//   FramesOk, FramesDropped   wrapping frame counters (CNT_W bits)
module hdlc_rx_drain #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned MAX_LEN = 126
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Enable,
    input  logic             Rx_Ready,
    output logic [2:0]       Address,
    output logic             ReadEnable,
    output logic             WriteEnable,
    output logic [7:0]       DataIn,
    input  logic [7:0]       DataOut,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [7:0]       m_data,
    output logic             m_last,
    output logic             m_err,
    output logic             Busy,
    output logic [CNT_W-1:0] FramesOk,
    output logic [CNT_W-1:0] FramesDropped
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_RD_SC    = 4'd1;
    localparam logic [3:0] S_CAP_SC   = 4'd2;
    localparam logic [3:0] S_RD_LEN   = 4'd3;
    localparam logic [3:0] S_CAP_LEN  = 4'd4;
    localparam logic [3:0] S_RD_BUF   = 4'd5;
    localparam logic [3:0] S_CAP_BUF  = 4'd6;
    localparam logic [3:0] S_PUSH     = 4'd7;
    localparam logic [3:0] S_DROP     = 4'd8;
    localparam logic [3:0] S_ERRBEAT  = 4'd9;
    localparam logic [3:0] S_WAIT_CLR = 4'd10;

    localparam logic [2:0] A_SC   = 3'd2;
    localparam logic [2:0] A_BUFF = 3'd3;
    localparam logic [2:0] A_LEN  = 3'd4;
    localparam logic [7:0] DROP_CMD = 8'h02;

    // State and datapath registers
    logic [3:0]       r_state;
    logic [7:0]       r_status;
    logic [7:0]       r_rem;
    logic [2:0]       r_addr;
    logic             r_re;
    logic             r_we;
    logic [7:0]       r_din;
    logic             r_m_valid;
    logic [7:0]       r_m_data;
    logic             r_m_last;
    logic             r_busy;
    logic [CNT_W-1:0] r_frames_ok;
    logic [CNT_W-1:0] r_frames_dropped;
`ifdef HDLC_RX_DRAIN_ERRBEAT_EN
    logic             r_m_err;
    logic             w_m_err_nxt;
`endif

    // Next-state values
    logic [3:0]       w_state_nxt;
    logic [7:0]       w_status_nxt;
    logic [7:0]       w_rem_nxt;
    logic [2:0]       w_addr_nxt;
    logic             w_re_nxt;
    logic             w_we_nxt;
    logic [7:0]       w_din_nxt;
    logic             w_m_valid_nxt;
    logic [7:0]       w_m_data_nxt;
    logic             w_m_last_nxt;
    logic [CNT_W-1:0] w_frames_ok_nxt;
    logic [CNT_W-1:0] w_frames_dropped_nxt;
    logic             w_hdr_err;

    // Header is bad on FrameError/Abort/Overflow status or an out-of-range length
    assign w_hdr_err = (|r_status[4:2]) || (DataOut == 8'd0) || (32'(DataOut) > MAX_LEN);

    // State register and registered outputs
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state          <= S_IDLE;
            r_status         <= 8'd0;
            r_rem            <= 8'd0;
            r_addr           <= 3'd0;
            r_re             <= 1'b0;
            r_we             <= 1'b0;
            r_din            <= 8'd0;
            r_m_valid        <= 1'b0;
            r_m_data         <= 8'd0;
            r_m_last         <= 1'b0;
            r_busy           <= 1'b0;
            r_frames_ok      <= '0;
            r_frames_dropped <= '0;
`ifdef HDLC_RX_DRAIN_ERRBEAT_EN
            r_m_err          <= 1'b0;
`endif
        end else begin
            r_state          <= w_state_nxt;
            r_status         <= w_status_nxt;
            r_rem            <= w_rem_nxt;
            r_addr           <= w_addr_nxt;
            r_re             <= w_re_nxt;
            r_we             <= w_we_nxt;
            r_din            <= w_din_nxt;
            r_m_valid        <= w_m_valid_nxt;
            r_m_data         <= w_m_data_nxt;
            r_m_last         <= w_m_last_nxt;
            r_busy           <= (w_state_nxt != S_IDLE);
            r_frames_ok      <= w_frames_ok_nxt;
            r_frames_dropped <= w_frames_dropped_nxt;
`ifdef HDLC_RX_DRAIN_ERRBEAT_EN
            r_m_err          <= w_m_err_nxt;
`endif
        end
    end

    // Next-state logic; bus/stream outputs are decided for the state being entered
    always_comb begin
        w_state_nxt          = r_state;
        w_status_nxt         = r_status;
        w_rem_nxt            = r_rem;
        w_addr_nxt           = 3'd0;
        w_re_nxt             = 1'b0;
        w_we_nxt             = 1'b0;
        w_din_nxt            = 8'd0;
        w_m_valid_nxt        = 1'b0;
        w_m_data_nxt         = 8'd0;
        w_m_last_nxt         = 1'b0;
        w_frames_ok_nxt      = r_frames_ok;
        w_frames_dropped_nxt = r_frames_dropped;
`ifdef HDLC_RX_DRAIN_ERRBEAT_EN
        w_m_err_nxt          = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (Enable && Rx_Ready) begin
                    w_state_nxt = S_RD_SC;
                    w_addr_nxt  = A_SC;
                    w_re_nxt    = 1'b1;
                end
            end
            S_RD_SC: w_state_nxt = S_CAP_SC;
            S_CAP_SC: begin
                w_status_nxt = DataOut;
                w_state_nxt  = S_RD_LEN;
                w_addr_nxt   = A_LEN;
                w_re_nxt     = 1'b1;
            end
            S_RD_LEN: w_state_nxt = S_CAP_LEN;
            S_CAP_LEN: begin
                if (w_hdr_err) begin
`ifdef HDLC_RX_DRAIN_ERRBEAT_EN
                    w_state_nxt   = S_ERRBEAT;
                    w_m_valid_nxt = 1'b1;
                    w_m_data_nxt  = r_status;
                    w_m_last_nxt  = 1'b1;
                    w_m_err_nxt   = 1'b1;
`else
                    w_state_nxt = S_DROP;
                    w_addr_nxt  = A_SC;
                    w_we_nxt    = 1'b1;
                    w_din_nxt   = DROP_CMD;
`endif
                end else begin
                    w_state_nxt = S_RD_BUF;
                    w_rem_nxt   = DataOut;
                    w_addr_nxt  = A_BUFF;
                    w_re_nxt    = 1'b1;
                end
            end
            S_RD_BUF: w_state_nxt = S_CAP_BUF;
            S_CAP_BUF: begin
                w_state_nxt   = S_PUSH;
                w_m_valid_nxt = 1'b1;
                w_m_data_nxt  = DataOut;
                w_m_last_nxt  = (r_rem == 8'd1);
                w_rem_nxt     = r_rem - 8'd1;
            end
            S_PUSH: begin
                if (m_ready) begin
                    if (r_m_last) begin
                        w_frames_ok_nxt = r_frames_ok + CNT_W'(1);
                        w_state_nxt     = S_WAIT_CLR;
                    end else begin
                        // Next read issues only after the current byte is taken
                        w_state_nxt = S_RD_BUF;
                        w_addr_nxt  = A_BUFF;
                        w_re_nxt    = 1'b1;
                    end
                end else begin
                    w_m_valid_nxt = 1'b1;
                    w_m_data_nxt  = r_m_data;
                    w_m_last_nxt  = r_m_last;
                end
            end
            S_DROP: begin
                w_frames_dropped_nxt = r_frames_dropped + CNT_W'(1);
                w_state_nxt          = S_WAIT_CLR;
            end
            S_ERRBEAT: begin
                if (m_ready) begin
                    w_state_nxt = S_DROP;
                    w_addr_nxt  = A_SC;
                    w_we_nxt    = 1'b1;
                    w_din_nxt   = DROP_CMD;
                end else begin
                    w_m_valid_nxt = 1'b1;
                    w_m_data_nxt  = r_status;
                    w_m_last_nxt  = 1'b1;
`ifdef HDLC_RX_DRAIN_ERRBEAT_EN
                    w_m_err_nxt   = 1'b1;
`endif
                end
            end
            S_WAIT_CLR: begin
                // Wait for Hdlc to retire the frame so it is not read twice
                if (!Rx_Ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign Address       = r_addr;
    assign ReadEnable    = r_re;
    assign WriteEnable   = r_we;
    assign DataIn        = r_din;
    assign m_valid       = r_m_valid;
    assign m_data        = r_m_data;
    assign m_last        = r_m_last;
    assign Busy          = r_busy;
    assign FramesOk      = r_frames_ok;
    assign FramesDropped = r_frames_dropped;
`ifdef HDLC_RX_DRAIN_ERRBEAT_EN
    assign m_err         = r_m_err;
`else
    assign m_err         = 1'b0;
`endif

endmodule

// File: tb/tb_hdlc_rx_drain.sv
// Testbench for hdlc_rx_drain: behavioural Hdlc register slave plus a
// scoreboard of expected stream beats checked at every handshake.
module tb_hdlc_rx_drain;

    logic        Clk;
    logic        Rst;
    logic        Enable;
    logic        Rx_Ready;
    logic [2:0]  Address;
    logic        ReadEnable;
    logic        WriteEnable;
    logic [7:0]  DataIn;
    logic [7:0]  DataOut;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic        m_last;
    logic        m_err;
    logic        Busy;
    logic [15:0] FramesOk;
    logic [15:0] FramesDropped;

    hdlc_rx_drain #(.CNT_W(16), .MAX_LEN(126)) dut (
        .Clk(Clk), .Rst(Rst), .Enable(Enable), .Rx_Ready(Rx_Ready),
        .Address(Address), .ReadEnable(ReadEnable), .WriteEnable(WriteEnable),
        .DataIn(DataIn), .DataOut(DataOut),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last(m_last), .m_err(m_err), .Busy(Busy),
        .FramesOk(FramesOk), .FramesDropped(FramesDropped)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    typedef struct packed {
        logic [7:0] d;
        logic       last;
        logic       err;
    } beat_t;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    int    n_beats  = 0;

    // Hdlc register model
    logic [7:0] h_sc;
    logic [7:0] h_len;
    logic [7:0] fbytes [0:255];
    int         h_idx      = 0;
    int         n_sc_reads = 0;
    int         n_writes   = 0;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;

    always @(posedge Clk) begin
        if (ReadEnable) begin
            case (Address)
                3'd2: begin DataOut <= h_sc; n_sc_reads++; h_idx = 0; end
                3'd4: DataOut <= h_len;
                3'd3: begin DataOut <= fbytes[h_idx]; h_idx++; end
                default: DataOut <= 8'hxx;
            endcase
        end
        if (WriteEnable) begin
            n_writes++;
            wr_addr <= Address;
            wr_data <= DataIn;
        end
    end

    // Stream scoreboard and bus strobe exclusivity
    always @(negedge Clk) begin
        if (Rst) begin
            if (ReadEnable || WriteEnable) begin
                n_checks++;
                if (ReadEnable && WriteEnable)
                    $display("FAIL strobe_excl: RE=%b WE=%b, required not both", ReadEnable, WriteEnable);
                else n_pass++;
            end
            if (m_valid && m_ready) begin
                beat_t e;
                n_beats++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_beat: data=%h last=%b err=%b, required no beat", m_data, m_last, m_err);
                end else begin
                    e = exp_q.pop_front();
                    if ({m_data, m_last, m_err} !== {e.d, e.last, e.err})
                        $display("FAIL beat: data=%h last=%b err=%b, required data=%h last=%b err=%b",
                                 m_data, m_last, m_err, e.d, e.last, e.err);
                    else n_pass++;
                end
            end
        end
    end

    // Program the Hdlc model for one frame and queue the expected beats
    task automatic load_frame(input logic [7:0] sc, input logic [7:0] len, input bit good);
        beat_t b;
        h_sc  = sc;
        h_len = len;
        if (good) begin
            for (int i = 0; i < int'(len); i++) begin
                b.d = fbytes[i]; b.last = (i == int'(len) - 1); b.err = 1'b0;
                exp_q.push_back(b);
            end
        end else begin
`ifdef HDLC_RX_DRAIN_ERRBEAT_EN
            b.d = sc; b.last = 1'b1; b.err = 1'b1;
            exp_q.push_back(b);
`endif
        end
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) fbytes[i] = 8'($urandom);
    endtask

    task automatic trigger();
        @(posedge Clk); #1;
        Rx_Ready = 1'b1;
    endtask

    task automatic wait_counted(output bit to_flag);
        int s0;
        s0 = int'(FramesOk) + int'(FramesDropped);
        to_flag = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge Clk);
            if (int'(FramesOk) + int'(FramesDropped) != s0) begin to_flag = 1'b0; break; end
        end
    endtask

    task automatic wait_idle(output bit to_flag);
        @(posedge Clk); #1;
        Rx_Ready = 1'b0;
        to_flag = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge Clk);
            if (!Busy) begin to_flag = 1'b0; break; end
        end
    endtask

    task automatic test_reset();
        Rst = 1'b0; Enable = 1'b0; Rx_Ready = 1'b0; m_ready = 1'b0;
        repeat (3) @(negedge Clk);
        n_checks++;
        if ({Address, ReadEnable, WriteEnable, DataIn, m_valid, m_data, m_last, m_err, Busy} !== 25'd0)
            $display("FAIL reset_outputs: addr=%h re=%b we=%b din=%h v=%b d=%h l=%b e=%b busy=%b, required all 0",
                     Address, ReadEnable, WriteEnable, DataIn, m_valid, m_data, m_last, m_err, Busy);
        else n_pass++;
        n_checks++;
        if (FramesOk !== 16'd0 || FramesDropped !== 16'd0)
            $display("FAIL reset_counters: ok=%0d dropped=%0d, required 0 0", FramesOk, FramesDropped);
        else n_pass++;
        @(posedge Clk); #1;
        Rst = 1'b1; Enable = 1'b1;
    endtask

    task automatic test_clean_frame();
        bit to_flag;
        logic [15:0] ok0;
        logic exp_re, exp_v;
        logic [2:0] exp_a;
        fbytes[0] = 8'hA5; fbytes[1] = 8'h3C; fbytes[2] = 8'hFF;
        load_frame(8'h01, 8'd3, 1'b1);
        m_ready = 1'b1;
        ok0 = FramesOk;
        trigger();
        for (int n = 0; n <= 7; n++) begin
            @(negedge Clk);
            exp_re = (n == 1 || n == 3 || n == 5);
            exp_a  = (n == 1) ? 3'd2 : (n == 3) ? 3'd4 : (n == 5) ? 3'd3 : 3'd0;
            exp_v  = (n == 7);
            n_checks++;
            if ({ReadEnable, Address, m_valid} !== {exp_re, exp_a, exp_v})
                $display("FAIL clean_timing cyc%0d: re=%b addr=%0d valid=%b, required re=%b addr=%0d valid=%b",
                         n, ReadEnable, Address, m_valid, exp_re, exp_a, exp_v);
            else n_pass++;
        end
        wait_counted(to_flag);
        n_checks++;
        if (to_flag) $display("FAIL clean_done: timed out, required frame completion");
        else n_pass++;
        wait_idle(to_flag);
        n_checks++;
        if (to_flag || FramesOk !== ok0 + 16'd1 || exp_q.size() != 0)
            $display("FAIL clean_count: ok=%0d left=%0d to=%b, required ok=%0d left=0 to=0",
                     FramesOk, exp_q.size(), to_flag, ok0 + 16'd1);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        bit to_flag;
        int b0;
        fill_random(4);
        load_frame(8'h00, 8'd4, 1'b1);
        m_ready = 1'b1;
        b0 = n_beats;
        trigger();
        to_flag = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge Clk);
            if (n_beats == b0 + 1) begin to_flag = 1'b0; break; end
        end
        @(posedge Clk); #1;
        m_ready = 1'b0;
        Enable  = 1'b0;
        if (!to_flag) begin
            to_flag = 1'b1;
            for (int i = 0; i < 50; i++) begin
                @(negedge Clk);
                if (m_valid) begin to_flag = 1'b0; break; end
            end
        end
        n_checks++;
        if (to_flag) $display("FAIL bp_byte2: timed out, required byte 2 valid");
        else n_pass++;
        for (int k = 0; k < 10; k++) begin
            n_checks++;
            if (m_valid !== 1'b1 || m_data !== fbytes[1] || ReadEnable !== 1'b0)
                $display("FAIL bp_stall cyc%0d: valid=%b data=%h re=%b, required valid=1 data=%h re=0",
                         k, m_valid, m_data, ReadEnable, fbytes[1]);
            else n_pass++;
            @(negedge Clk);
        end
        @(posedge Clk); #1;
        m_ready = 1'b1;
        wait_counted(to_flag);
        Enable = 1'b1;
        n_checks++;
        if (to_flag || n_beats != b0 + 4 || exp_q.size() != 0)
            $display("FAIL bp_done: beats=%0d left=%0d to=%b, required beats=%0d left=0 to=0",
                     n_beats - b0, exp_q.size(), to_flag, 4);
        else n_pass++;
        wait_idle(to_flag);
    endtask

    task automatic test_abort();
        bit to_flag;
        int w0, b0;
        logic [15:0] d0, o0;
        fill_random(3);
        w0 = n_writes; b0 = n_beats; d0 = FramesDropped; o0 = FramesOk;
        load_frame(8'h09, 8'd3, 1'b0);
        m_ready = 1'b1;
        trigger();
`ifndef HDLC_RX_DRAIN_ERRBEAT_EN
        for (int n = 0; n <= 5; n++) @(negedge Clk);
        n_checks++;
        if ({WriteEnable, Address, DataIn} !== {1'b1, 3'd2, 8'h02})
            $display("FAIL abort_drop_cyc5: we=%b addr=%0d din=%h, required we=1 addr=2 din=02",
                     WriteEnable, Address, DataIn);
        else n_pass++;
`endif
        wait_counted(to_flag);
        wait_idle(to_flag);
        n_checks++;
        if (n_writes != w0 + 1 || wr_addr !== 3'd2 || wr_data !== 8'h02)
            $display("FAIL abort_write: writes=%0d addr=%0d data=%h, required writes=1 addr=2 data=02",
                     n_writes - w0, wr_addr, wr_data);
        else n_pass++;
        n_checks++;
        if (to_flag || FramesDropped !== d0 + 16'd1 || FramesOk !== o0)
            $display("FAIL abort_count: dropped=%0d ok=%0d to=%b, required dropped=%0d ok=%0d",
                     FramesDropped, FramesOk, to_flag, d0 + 16'd1, o0);
        else n_pass++;
        n_checks++;
`ifdef HDLC_RX_DRAIN_ERRBEAT_EN
        if (n_beats != b0 + 1) $display("FAIL abort_beats: beats=%0d, required 1", n_beats - b0);
`else
        if (n_beats != b0) $display("FAIL abort_beats: beats=%0d, required 0", n_beats - b0);
`endif
        else n_pass++;
    endtask

    task automatic test_len_bounds();
        bit to_flag;
        int w0;
        logic [15:0] d0, o0;
        logic [7:0] bad_len [0:1];
        bad_len[0] = 8'd0; bad_len[1] = 8'd127;
        m_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            fill_random(128);
            w0 = n_writes; d0 = FramesDropped; o0 = FramesOk;
            load_frame(8'h00, bad_len[k], 1'b0);
            trigger();
            wait_counted(to_flag);
            wait_idle(to_flag);
            n_checks++;
            if (to_flag || FramesDropped !== d0 + 16'd1 || FramesOk !== o0 || n_writes != w0 + 1)
                $display("FAIL len_drop len=%0d: dropped=%0d ok=%0d writes=%0d, required dropped=%0d ok=%0d writes=1",
                         bad_len[k], FramesDropped, FramesOk, n_writes - w0, d0 + 16'd1, o0);
            else n_pass++;
        end
        fill_random(126);
        o0 = FramesOk;
        load_frame(8'h00, 8'd126, 1'b1);
        trigger();
        wait_counted(to_flag);
        wait_idle(to_flag);
        n_checks++;
        if (to_flag || FramesOk !== o0 + 16'd1 || exp_q.size() != 0)
            $display("FAIL len_126: ok=%0d left=%0d to=%b, required ok=%0d left=0",
                     FramesOk, exp_q.size(), to_flag, o0 + 16'd1);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit to_flag;
        int b0;
        fill_random(10);
        load_frame(8'h00, 8'd10, 1'b1);
        m_ready = 1'b1;
        b0 = n_beats;
        trigger();
        to_flag = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge Clk);
            if (n_beats == b0 + 5) begin to_flag = 1'b0; break; end
        end
        n_checks++;
        if (to_flag) $display("FAIL rstmid_byte5: timed out, required byte 5");
        else n_pass++;
        #2 Rst = 1'b0;
        #1;
        n_checks++;
        if ({Address, ReadEnable, WriteEnable, DataIn, m_valid, m_data, m_last, m_err, Busy} !== 25'd0 ||
            FramesOk !== 16'd0 || FramesDropped !== 16'd0)
            $display("FAIL rstmid_outputs: valid=%b data=%h busy=%b ok=%0d dropped=%0d, required all 0",
                     m_valid, m_data, Busy, FramesOk, FramesDropped);
        else n_pass++;
        exp_q.delete();
        @(posedge Clk); #1;
        Rst = 1'b1;
        load_frame(8'h00, 8'd10, 1'b1);
        @(negedge Clk);
        @(negedge Clk);
        n_checks++;
        if (ReadEnable !== 1'b1 || Address !== 3'd2)
            $display("FAIL rstmid_restart: re=%b addr=%0d, required re=1 addr=2", ReadEnable, Address);
        else n_pass++;
        wait_counted(to_flag);
        wait_idle(to_flag);
        n_checks++;
        if (to_flag || FramesOk !== 16'd1 || exp_q.size() != 0)
            $display("FAIL rstmid_after: ok=%0d left=%0d to=%b, required ok=1 left=0", FramesOk, exp_q.size(), to_flag);
        else n_pass++;
    endtask

    task automatic test_reread_guard();
        bit to_flag;
        int s0;
        fill_random(2);
        load_frame(8'h00, 8'd2, 1'b1);
        m_ready = 1'b1;
        trigger();
        wait_counted(to_flag);
        s0 = n_sc_reads;
        repeat (20) @(negedge Clk);
        n_checks++;
        if (to_flag || n_sc_reads != s0 || Busy !== 1'b1)
            $display("FAIL reread_hold: sc_reads=%0d busy=%b to=%b, required sc_reads=0 busy=1",
                     n_sc_reads - s0, Busy, to_flag);
        else n_pass++;
        wait_idle(to_flag);
        fill_random(2);
        load_frame(8'h00, 8'd2, 1'b1);
        trigger();
        @(negedge Clk); @(negedge Clk); @(negedge Clk);
        n_checks++;
        if (n_sc_reads != s0 + 1)
            $display("FAIL reread_new: sc_reads=%0d, required 1", n_sc_reads - s0);
        else n_pass++;
        wait_counted(to_flag);
        wait_idle(to_flag);
        n_checks++;
        if (to_flag || exp_q.size() != 0)
            $display("FAIL reread_done: left=%0d to=%b, required left=0 to=0", exp_q.size(), to_flag);
        else n_pass++;
    endtask

    initial begin
        DataOut = 8'd0;
        h_sc = 8'd0; h_len = 8'd0;
        test_reset();
        test_clean_frame();
        test_backpressure();
        test_abort();
        test_len_bounds();
        test_reset_mid();
        test_reread_guard();
        repeat (2) @(negedge Clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
